// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter.
//   UART_DATA_W  : payload width of one serial frame
//   uart_state_e : frame-level FSM states
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin.
// Both flops reset to 1 so that a reset looks like an idle line and cannot
// be mistaken for a start bit.
//   clk   in  system clock
//   rst   in  asynchronous, active-high reset
//   d     in  asynchronous serial input
//   q     out synchronized copy of d (two clk cycles of latency)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start(0), 8 data bits LSB first, even parity, stop(1).
// The line is oversampled CLKS_PER_BIT times per bit and sampled mid-bit.
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   rx          in   serial input, asynchronous to clk, idles high
//   data_out    out  last received byte, held until the next valid
//   valid       out  one-cycle strobe: data_out and error flags updated
//   parity_err  out  received parity bit disagreed with ^data_out
//   frame_err   out  stop bit was sampled low
//   busy        out  a frame is in progress (FSM not in IDLE)
// Handshake: valid is a pure strobe with no ready; the consumer must take
// data_out/parity_err/frame_err in the cycle valid is high. The values stay
// stable until the next strobe, and valid never stays high two cycles.
// The FSM state is held in state_q for observation by checkers.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
  // The first wait is half a bit so every later sample lands mid-bit.
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic rs;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rs)
  );

  uart_state_e            state_q,  state_d;
  logic [TW-1:0]          tick_q,   tick_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q,  shift_d;
  logic                   parity_q, parity_d;
  logic [UART_DATA_W-1:0] data_q,   data_d;
  logic                   perr_q,   perr_d;
  logic                   ferr_q,   ferr_d;
  logic                   valid_q,  valid_d;

  logic tick_zero;
  assign tick_zero = (tick_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rs) state_d = START;
      end
      START: begin
        // A low that has vanished by mid-bit is a glitch, not a start bit.
        if (tick_zero) state_d = rs ? IDLE : DATA;
      end
      DATA: begin
        if (tick_zero && (bit_idx_q == 3'd7)) state_d = PARITY;
      end
      PARITY: begin
        if (tick_zero) state_d = STOP;
      end
      STOP: begin
        // A low stop bit may be a line break; wait for the line to recover
        // before hunting for the next start bit.
        if (tick_zero) state_d = rs ? IDLE : BREAK;
      end
      BREAK: begin
        if (rs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Counters, shift register and result registers
  always_comb begin
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rs) tick_d = TICK_HALF;
      end
      START: begin
        if (tick_zero) begin
          if (!rs) begin
            tick_d    = TICK_FULL;
            bit_idx_d = 3'd0;
          end
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      DATA: begin
        if (tick_zero) begin
          shift_d = {rs, shift_q[UART_DATA_W-1:1]};
          tick_d  = TICK_FULL;
          // bit_idx parks at 7 rather than wrapping.
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      PARITY: begin
        if (tick_zero) begin
          parity_d = rs;
          tick_d   = TICK_FULL;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      STOP: begin
        if (tick_zero) begin
          data_d  = shift_q;
          perr_d  = parity_q ^ (^shift_q);
          ferr_d  = ~rs;
          valid_d = 1'b1;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at CLKS_PER_BIT=4, one at 16.
// Frames are built from the line format; the expected byte, flags, busy level
// and strobe cycle are computed from the frame's bits and its start time.
module tb_uart_rx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx4 = 1'b1;
  logic rx16 = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d4, d16;
  logic v4, v16, pe4, pe16, fe4, fe16, b4, b16;

  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .rx(rx4), .data_out(d4), .valid(v4),
    .parity_err(pe4), .frame_err(fe4), .busy(b4)
  );

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .rx(rx16), .data_out(d16), .valid(v16),
    .parity_err(pe16), .frame_err(fe16), .busy(b16)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic        busy;
    logic [31:0] cyc;
  } ev_t;

  ev_t obs4[$], obs16[$], exp4[$], exp16[$];
  int n_vec = 0;
  int n_err = 0;
  int dbl_valid = 0;
  int stray_change = 0;
  logic pv4 = 1'b0, pv16 = 1'b0;
  logic [9:0] prev4 = '0, prev16 = '0;

  // Monitor: records each strobe and notes protocol violations.
  always @(negedge clk) begin
    if (v4)  obs4.push_back({d4, pe4, fe4, b4, 32'(cyc)});
    if (v16) obs16.push_back({d16, pe16, fe16, b16, 32'(cyc)});
    if ((v4 && pv4) || (v16 && pv16)) dbl_valid <= dbl_valid + 1;
    if (!rst && !v4 && ({d4, pe4, fe4} !== prev4)) stray_change <= stray_change + 1;
    if (!rst && !v16 && ({d16, pe16, fe16} !== prev16)) stray_change <= stray_change + 1;
    pv4    <= v4;
    pv16   <= v16;
    prev4  <= {d4, pe4, fe4};
    prev16 <= {d16, pe16, fe16};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All drivers assume they are entered 1 time unit after a posedge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx16 = b;
    else     rx4  = b;
  endtask

  // Sends one frame and queues the reference event for it.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                            input logic stp, input int low_hold,
                            output logic busy_hold);
    int c;
    int e0;
    logic [10:0] bits;
    ev_t ev;
    c = sel ? 16 : 4;
    bits = {stp, par, d, 1'b0};
    e0 = cyc + 1;
    busy_hold = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(sel, bits[i]);
      wait_cyc(c);
    end
    if (!stp) begin
      if (low_hold > 0) wait_cyc(low_hold);
      busy_hold = sel ? b16 : b4;
      drive(sel, 1'b1);
      wait_cyc(c);
    end
    ev.d    = d;
    ev.pe   = par ^ (^d);
    ev.fe   = ~stp;
    ev.busy = ~stp;
    ev.cyc  = 32'(e0 + 2 + c / 2 + 10 * c);
    if (sel) exp16.push_back(ev);
    else     exp4.push_back(ev);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    wait_cyc(10);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({d4, v4, pe4, fe4, b4} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut4 got %h required 000", {d4, v4, pe4, fe4, b4});
    end
    n_vec++;
    if ({d16, v16, pe16, fe16, b16} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut16 got %h required 000", {d16, v16, pe16, fe16, b16});
    end
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(50);
    n_vec++;
    if ((obs4.size() + obs16.size()) != 0 || b4 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_line got valids=%0d busy=%b required valids=0 busy=0",
               obs4.size() + obs16.size(), b4);
    end
    obs4.delete();
    obs16.delete();
  endtask

  task automatic test_frames_basic;
    logic bh;
    ev_t e, o;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 0, bh);  // good frame
    send_frame(1'b0, 8'h01, 1'b0, 1'b1, 0, bh);  // wrong parity
    wait_cyc(20);
    n_vec++;
    if (obs4.size() != exp4.size()) begin
      n_err++;
      $display("FAIL basic_count got %0d valids required %0d", obs4.size(), exp4.size());
    end
    while (exp4.size() > 0 && obs4.size() > 0) begin
      e = exp4.pop_front();
      o = obs4.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_frame got d=%h pe=%b fe=%b busy=%b cyc=%0d required d=%h pe=%b fe=%b busy=%b cyc=%0d",
                 o.d, o.pe, o.fe, o.busy, o.cyc, e.d, e.pe, e.fe, e.busy, e.cyc);
      end
    end
    exp4.delete();
    obs4.delete();
    n_vec++;
    if ({d4, pe4} !== {8'h01, 1'b1}) begin
      n_err++;
      $display("FAIL held_output got d=%h pe=%b required d=01 pe=1", d4, pe4);
    end
  endtask

  task automatic test_frame_err;
    logic bh;
    ev_t e, o;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 20, bh);
    n_vec++;
    if (bh !== 1'b1) begin
      n_err++;
      $display("FAIL break_busy got %b required 1", bh);
    end
    n_vec++;
    if (b4 !== 1'b0) begin
      n_err++;
      $display("FAIL break_release got busy=%b required 0", b4);
    end
    wait_cyc(10);
    n_vec++;
    if (obs4.size() != 1) begin
      n_err++;
      $display("FAIL break_count got %0d valids required 1", obs4.size());
    end
    if (obs4.size() > 0 && exp4.size() > 0) begin
      e = exp4.pop_front();
      o = obs4.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL break_frame got d=%h pe=%b fe=%b busy=%b cyc=%0d required d=%h pe=%b fe=%b busy=%b cyc=%0d",
                 o.d, o.pe, o.fe, o.busy, o.cyc, e.d, e.pe, e.fe, e.busy, e.cyc);
      end
    end
    exp4.delete();
    obs4.delete();
  endtask

  task automatic test_glitch;
    drive(1'b0, 1'b0);
    wait_cyc(1);
    drive(1'b0, 1'b1);
    wait_cyc(2);
    n_vec++;
    if (b4 !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_start got busy=%b required 1", b4);
    end
    wait_cyc(3);
    n_vec++;
    if (b4 !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_reject got busy=%b required 0", b4);
    end
    wait_cyc(60);
    n_vec++;
    if (obs4.size() != 0) begin
      n_err++;
      $display("FAIL glitch_valid got %0d valids required 0", obs4.size());
    end
    obs4.delete();
  endtask

  task automatic test_random;
    logic bh;
    logic [7:0] d;
    logic par, stp;
    ev_t e, o;
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom_range(0, 255));
      par = (^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, d, par, stp, $urandom_range(0, 12), bh);
      if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(1, 6));
    end
    wait_cyc(20);
    n_vec++;
    if (obs4.size() != exp4.size()) begin
      n_err++;
      $display("FAIL random_count got %0d valids required %0d", obs4.size(), exp4.size());
    end
    while (exp4.size() > 0 && obs4.size() > 0) begin
      e = exp4.pop_front();
      o = obs4.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random_frame got d=%h pe=%b fe=%b busy=%b cyc=%0d required d=%h pe=%b fe=%b busy=%b cyc=%0d",
                 o.d, o.pe, o.fe, o.busy, o.cyc, e.d, e.pe, e.fe, e.busy, e.cyc);
      end
    end
    exp4.delete();
    obs4.delete();
  endtask

  task automatic test_back_to_back;
    logic bh;
    ev_t e, o;
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 0, bh);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b1, 0, bh);
    send_frame(1'b1, 8'h55, 1'b0, 1'b1, 0, bh);
    // Partial fourth frame: start bit, then a 1 data bit, then abort.
    drive(1'b1, 1'b0);
    wait_cyc(16);
    drive(1'b1, 1'b1);
    wait_cyc(24);
    n_vec++;
    if (b16 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_fourth_busy got %b required 1", b16);
    end
    n_vec++;
    if (obs16.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count got %0d valids required 3", obs16.size());
    end
    while (exp16.size() > 0 && obs16.size() > 0) begin
      e = exp16.pop_front();
      o = obs16.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b_frame got d=%h pe=%b fe=%b busy=%b cyc=%0d required d=%h pe=%b fe=%b busy=%b cyc=%0d",
                 o.d, o.pe, o.fe, o.busy, o.cyc, e.d, e.pe, e.fe, e.busy, e.cyc);
      end
    end
    exp16.delete();
    obs16.delete();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({d16, v16, pe16, fe16, b16} !== 12'h000) begin
      n_err++;
      $display("FAIL midframe_reset got %h required 000", {d16, v16, pe16, fe16, b16});
    end
    drive(1'b1, 1'b1);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(250);
    n_vec++;
    if (obs16.size() != 0 || b16 !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset got valids=%0d busy=%b required valids=0 busy=0",
               obs16.size(), b16);
    end
    obs16.delete();
  endtask

  task automatic test_invariants;
    n_vec++;
    if (dbl_valid != 0) begin
      n_err++;
      $display("FAIL valid_twice got %0d required 0", dbl_valid);
    end
    n_vec++;
    if (stray_change != 0) begin
      n_err++;
      $display("FAIL flags_without_valid got %0d required 0", stray_change);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_frames_basic();
    test_frame_err();
    test_glitch();
    test_random();
    test_back_to_back();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
